// File: rtl/rr_mux_stage.sv
// rtl/rr_mux_stage.sv - registered N:1 valid/ready mux with round-robin or fixed-priority arbitration
module rr_mux_stage #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int RR       = 1,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready
);

    logic [CW-1:0]       ptr;
    logic                load_en;
    logic                found;
    logic                accept;
    logic [CHANNELS-1:0] rot;
    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       grant_idx;
    logic [WIDTH-1:0]    sel_data;
    int                  off;
    int                  sum;

    assign load_en = !out_valid | out_ready;
    assign accept  = load_en & found;

    // Rotate the valids so ptr sits at bit 0, take the lowest set bit, then map back to a channel index
    always_comb begin
        rot       = CHANNELS'({in_valid, in_valid} >> ptr);
        found     = 1'b0;
        off       = 0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= CHANNELS) begin
            sum = sum - CHANNELS;
        end
        grant_idx = CW'(sum);
        grant     = found ? (CHANNELS'(1) << grant_idx) : '0;
    end

    // Word mux driven only by the grant index; in_data never reaches an output combinationally
    always_comb begin
        sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // Handshake back to producers, forced low while reset is held
    always_comb begin
        in_ready = (load_en && !rst) ? grant : '0;
    end

    // Output register: accept replaces the word, drain without accept only clears valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Arbitration pointer moves past the winner only in round-robin mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && (RR != 0) && (CHANNELS > 1)) begin
            ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + CW'(1);
        end
    end

endmodule
